// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register target.
package spi_reg_pkg;

    typedef enum logic [1:0] {IDLE, CMD, DATA} spi_tgt_state_e;

    localparam int CMD_RW_BIT = 7;
    localparam int BYTE_BITS  = 8;

endpackage

// File: rtl/spi_reg_target_sync.sv
// Two-flop synchroniser with rise/fall strobes for one asynchronous SPI pin.
module spi_pin_sync
    import spi_reg_pkg::*;
#(
    parameter logic RST_LVL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Reset to the pin's idle level so no edge is seen right after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_LVL;
            r_sync <= RST_LVL;
            r_prev <= RST_LVL;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/spi_reg_target.sv
// SPI target with an 8-bit register bank; command byte then data bytes, MSB first.
// Define SPI_REG_AUTOINC_EN to step the address after every data byte (burst access).
module spi_reg_target
    import spi_reg_pkg::*;
#(
    parameter int         NREGS   = 8,
    parameter int         ADDR_W  = $clog2(NREGS),
    parameter logic       CPOL    = 1'b0,
    parameter logic       CPHA    = 1'b0,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ssn,
    input  logic                 scki,
    input  logic                 mosii,
    output logic                 misoo,
    output logic                 misooe,
    output logic [NREGS*8-1:0]   reg_q,
    output logic                 wr_stb,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [7:0]           wr_data,
    output logic                 frame_done
);

    localparam int                CNT_W    = $clog2(BYTE_BITS);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(BYTE_BITS - 1);
`ifdef SPI_REG_AUTOINC_EN
    localparam logic AUTOINC = 1'b1;
`else
    localparam logic AUTOINC = 1'b0;
`endif

    logic w_ssnLevel, w_ssnRise, w_ssnFall;
    logic w_unusedSckLevel, w_sckRise, w_sckFall;
    logic w_mosi, w_unusedMosiRise, w_unusedMosiFall;

    spi_pin_sync #(.RST_LVL(1'b1)) u_ssnSync (
        .clk(clk), .rst_n(rst_n), .i_pin(ssn),
        .o_level(w_ssnLevel), .o_rise(w_ssnRise), .o_fall(w_ssnFall)
    );

    spi_pin_sync #(.RST_LVL(CPOL)) u_sckSync (
        .clk(clk), .rst_n(rst_n), .i_pin(scki),
        .o_level(w_unusedSckLevel), .o_rise(w_sckRise), .o_fall(w_sckFall)
    );

    spi_pin_sync #(.RST_LVL(1'b0)) u_mosiSync (
        .clk(clk), .rst_n(rst_n), .i_pin(mosii),
        .o_level(w_mosi), .o_rise(w_unusedMosiRise), .o_fall(w_unusedMosiFall)
    );

    spi_tgt_state_e r_state, w_nextState;

    logic [CNT_W-1:0]     r_bitCnt;
    logic [BYTE_BITS-1:0] r_shiftIn;
    logic [BYTE_BITS-1:0] r_shiftOut;
    logic                 r_rw;
    logic [ADDR_W-1:0]    r_addr;
    logic                 r_first;
    logic                 r_misoo;
    logic                 r_misooe;
    logic                 r_wrStb;
    logic [ADDR_W-1:0]    r_wrAddr;
    logic [7:0]           r_wrData;
    logic                 r_frameDone;
    logic [7:0]           r_regs [NREGS];

    logic                 w_lead, w_trail, w_sample, w_shift, w_byteLast;
    logic                 w_cmdDone, w_dataDone, w_frameEnd, w_regWe;
    logic [BYTE_BITS-1:0] w_byte;
    logic [ADDR_W-1:0]    w_cmdAddr, w_nextAddr;

    // Leading edge leaves CPOL; CPHA picks which edge samples and which shifts
    assign w_lead     = CPOL ? w_sckFall : w_sckRise;
    assign w_trail    = CPOL ? w_sckRise : w_sckFall;
    assign w_sample   = CPHA ? w_trail : w_lead;
    assign w_shift    = CPHA ? w_lead : w_trail;
    assign w_byte     = {r_shiftIn[BYTE_BITS-2:0], w_mosi};
    assign w_byteLast = w_sample && (r_bitCnt == LAST_BIT);
    assign w_cmdAddr  = w_byte[ADDR_W-1:0];
    assign w_nextAddr = r_addr + ADDR_W'(1);
    assign w_regWe    = w_dataDone && !r_rw && (AUTOINC || r_first);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    // A byte finishing in the same clk as ssn rising still completes
    always_comb begin
        w_nextState = r_state;
        w_cmdDone   = 1'b0;
        w_dataDone  = 1'b0;
        w_frameEnd  = 1'b0;
        case (r_state)
            IDLE: if (w_ssnFall) w_nextState = CMD;
            CMD: begin
                if (w_byteLast) begin
                    w_cmdDone   = 1'b1;
                    w_nextState = DATA;
                end
            end
            DATA:    if (w_byteLast) w_dataDone = 1'b1;
            default: w_nextState = IDLE;
        endcase
        if (w_ssnRise && (r_state != IDLE)) begin
            w_nextState = IDLE;
            w_frameEnd  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= RST_VAL;
        end else if (w_regWe) begin
            r_regs[r_addr] <= w_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bitCnt    <= '0;
            r_shiftIn   <= '0;
            r_shiftOut  <= '0;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_first     <= 1'b0;
            r_misoo     <= 1'b0;
            r_misooe    <= 1'b0;
            r_wrStb     <= 1'b0;
            r_wrAddr    <= '0;
            r_wrData    <= '0;
            r_frameDone <= 1'b0;
        end else begin
            r_wrStb     <= w_regWe;
            r_frameDone <= w_frameEnd;
            r_misooe    <= ~w_ssnLevel;
            if (w_regWe) begin
                r_wrAddr <= r_addr;
                r_wrData <= w_byte;
            end
            if (r_state == IDLE) begin
                if (w_ssnFall) begin
                    r_bitCnt   <= '0;
                    r_shiftIn  <= '0;
                    r_shiftOut <= '0;
                    r_misoo    <= 1'b0;
                end
            end else begin
                if (w_sample) begin
                    r_shiftIn <= w_byte;
                    r_bitCnt  <= r_bitCnt + CNT_W'(1);
                end
                if (w_cmdDone) begin
                    r_rw       <= w_byte[CMD_RW_BIT];
                    r_addr     <= w_cmdAddr;
                    r_first    <= 1'b1;
                    r_shiftOut <= w_byte[CMD_RW_BIT] ? r_regs[w_cmdAddr] : '0;
                end
                // Without auto-increment, bytes after the first read back as zero
                if (w_dataDone) begin
                    r_first    <= 1'b0;
                    if (AUTOINC) r_addr <= w_nextAddr;
                    r_shiftOut <= AUTOINC ? r_regs[w_nextAddr] : '0;
                end
                if (w_shift && (r_state == DATA) && r_rw) begin
                    r_misoo    <= r_shiftOut[BYTE_BITS-1];
                    r_shiftOut <= {r_shiftOut[BYTE_BITS-2:0], 1'b0};
                end
                if (w_ssnRise) begin
                    r_bitCnt  <= '0;
                    r_shiftIn <= '0;
                    r_misoo   <= 1'b0;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NREGS; gi++) begin : gRegQ
        assign reg_q[8*gi +: 8] = r_regs[gi];
    end

    assign misoo      = r_misoo;
    assign misooe     = r_misooe;
    assign wr_stb     = r_wrStb;
    assign wr_addr    = r_wrAddr;
    assign wr_data    = r_wrData;
    assign frame_done = r_frameDone;

endmodule

// File: tb/tb_spi_reg_target.sv
// Directed bench: four targets (one per CPOL/CPHA mode) driven by a bit-banged SPI master.
module tb_spi_reg_target;

    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] ssnPin;
    logic [3:0] sckPin;
    logic [3:0] mosiPin;
    wire  [3:0] misoPin;
    wire  [3:0] misoOePin;
    wire  [3:0] wrStb;
    wire  [3:0] frameDone;
    wire  [63:0] regQ [4];
    wire  [2:0]  wrAddr [4];
    wire  [7:0]  wrData [4];

    int checks   = 0;
    int failures = 0;

    int         wrCnt [4]      = '{0, 0, 0, 0};
    int         fdCnt [4]      = '{0, 0, 0, 0};
    logic [2:0] lastWrAddr [4] = '{3'd0, 3'd0, 3'd0, 3'd0};
    logic [7:0] lastWrData [4] = '{8'd0, 8'd0, 8'd0, 8'd0};

    logic [7:0]  txBuf [4];
    logic [7:0]  rxBuf [4];
    logic [63:0] expQ [4];
    logic        oeDuring;
    int          wrB;
    int          fdB;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gDut
        spi_reg_target #(
            .NREGS(8), .ADDR_W(3), .CPOL(1'(g / 2)), .CPHA(1'(g % 2)), .RST_VAL(8'h00)
        ) dut (
            .clk(clk), .rst_n(rst_n), .ssn(ssnPin[g]), .scki(sckPin[g]), .mosii(mosiPin[g]),
            .misoo(misoPin[g]), .misooe(misoOePin[g]), .reg_q(regQ[g]),
            .wr_stb(wrStb[g]), .wr_addr(wrAddr[g]), .wr_data(wrData[g]),
            .frame_done(frameDone[g])
        );
    end

    // Pulses last one clk, so sampling at negedge counts each exactly once
    always @(negedge clk) begin
        for (int m = 0; m < 4; m++) begin
            if (wrStb[m]) begin
                wrCnt[m]      = wrCnt[m] + 1;
                lastWrAddr[m] = wrAddr[m];
                lastWrData[m] = wrData[m];
            end
            if (frameDone[m]) fdCnt[m] = fdCnt[m] + 1;
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic halfWait();
        repeat (8) @(negedge clk);
    endtask

    task automatic setExp(input int m, input int r, input logic [7:0] val);
        expQ[m][8*r +: 8] = val;
    endtask

    // One SPI frame of nBits from txBuf on instance `mode`; holdSsn leaves ssn low
    task automatic applyStimulus(input int mode, input int nBits, input bit holdSsn);
        logic cpol;
        logic cpha;
        cpol = (mode >= 2);
        cpha = (mode % 2 == 1);
        for (int k = 0; k < 4; k++) rxBuf[k] = 8'h00;
        @(negedge clk);
        ssnPin[mode] = 1'b0;
        if (!cpha) mosiPin[mode] = txBuf[0][7];
        halfWait();
        oeDuring = misoOePin[mode];
        for (int i = 0; i < nBits; i++) begin
            if (!cpha) begin
                rxBuf[i / 8][7 - (i % 8)] = misoPin[mode];
                sckPin[mode] = ~cpol;
                halfWait();
                sckPin[mode] = cpol;
                if (i + 1 < nBits) mosiPin[mode] = txBuf[(i + 1) / 8][7 - ((i + 1) % 8)];
                halfWait();
            end else begin
                sckPin[mode]  = ~cpol;
                mosiPin[mode] = txBuf[i / 8][7 - (i % 8)];
                halfWait();
                rxBuf[i / 8][7 - (i % 8)] = misoPin[mode];
                sckPin[mode] = cpol;
                halfWait();
            end
        end
        if (!holdSsn) begin
            ssnPin[mode]  = 1'b1;
            mosiPin[mode] = 1'b0;
            halfWait();
            halfWait();
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        ssnPin  = 4'hF;
        sckPin  = 4'b1100;
        mosiPin = 4'h0;
        for (int m = 0; m < 4; m++) expQ[m] = '0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        checkOutput("rst_misoo", 64'(misoPin), 64'h0);
        checkOutput("rst_misooe", 64'(misoOePin), 64'h0);
        checkOutput("rst_wrstb", 64'(wrStb), 64'h0);
        checkOutput("rst_wraddr", 64'(wrAddr[0]), 64'h0);
        checkOutput("rst_wrdata", 64'(wrData[0]), 64'h0);
        checkOutput("rst_fdone", 64'(frameDone), 64'h0);
        checkOutput("rst_regq", regQ[0], 64'h0);

        // Test 1: mode 00 write reg2 = A5
        txBuf = '{8'h02, 8'hA5, 8'h00, 8'h00};
        wrB = wrCnt[0]; fdB = fdCnt[0];
        applyStimulus(0, 16, 1'b0);
        setExp(0, 2, 8'hA5);
        checkOutput("t1_regq", regQ[0], expQ[0]);
        checkOutput("t1_wrcnt", 64'(wrCnt[0] - wrB), 64'd1);
        checkOutput("t1_wraddr", 64'(lastWrAddr[0]), 64'd2);
        checkOutput("t1_wrdata", 64'(lastWrData[0]), 64'hA5);
        checkOutput("t1_fdone", 64'(fdCnt[0] - fdB), 64'd1);

        // Test 2: mode 00 read reg2
        checkOutput("t2_oe_before", 64'(misoOePin[0]), 64'h0);
        txBuf = '{8'h82, 8'h00, 8'h00, 8'h00};
        wrB = wrCnt[0]; fdB = fdCnt[0];
        applyStimulus(0, 16, 1'b0);
        checkOutput("t2_cmd_miso", 64'(rxBuf[0]), 64'h00);
        checkOutput("t2_rdata", 64'(rxBuf[1]), 64'hA5);
        checkOutput("t2_oe_during", 64'(oeDuring), 64'h1);
        checkOutput("t2_oe_after", 64'(misoOePin[0]), 64'h0);
        checkOutput("t2_wrcnt", 64'(wrCnt[0] - wrB), 64'd0);
        checkOutput("t2_fdone", 64'(fdCnt[0] - fdB), 64'd1);

        // Test 3: every mode writes reg5 = 3C and reads it back
        for (int m = 0; m < 4; m++) begin
            txBuf = '{8'h05, 8'h3C, 8'h00, 8'h00};
            applyStimulus(m, 16, 1'b0);
            setExp(m, 5, 8'h3C);
            checkOutput($sformatf("t3_regq_m%0d", m), regQ[m], expQ[m]);
            txBuf = '{8'h85, 8'h00, 8'h00, 8'h00};
            applyStimulus(m, 16, 1'b0);
            checkOutput($sformatf("t3_rdata_m%0d", m), 64'(rxBuf[1]), 64'h3C);
        end

        // Test 4: burst write from reg6, then burst read
        txBuf = '{8'h06, 8'h11, 8'h22, 8'h33};
        wrB = wrCnt[0];
        applyStimulus(0, 32, 1'b0);
        setExp(0, 6, 8'h11);
`ifdef SPI_REG_AUTOINC_EN
        setExp(0, 7, 8'h22);
        setExp(0, 0, 8'h33);
        checkOutput("t4_wrcnt", 64'(wrCnt[0] - wrB), 64'd3);
        checkOutput("t4_wrdata", 64'(lastWrData[0]), 64'h33);
`else
        checkOutput("t4_wrcnt", 64'(wrCnt[0] - wrB), 64'd1);
        checkOutput("t4_wrdata", 64'(lastWrData[0]), 64'h11);
`endif
        checkOutput("t4_regq", regQ[0], expQ[0]);
        txBuf = '{8'h86, 8'h00, 8'h00, 8'h00};
        applyStimulus(0, 24, 1'b0);
        checkOutput("t4_rd0", 64'(rxBuf[1]), 64'h11);
`ifdef SPI_REG_AUTOINC_EN
        checkOutput("t4_rd1", 64'(rxBuf[2]), 64'h22);
`else
        checkOutput("t4_rd1", 64'(rxBuf[2]), 64'h00);
`endif

        // Test 5: ssn rises after 4 data bits
        txBuf = '{8'h01, 8'hFF, 8'h00, 8'h00};
        wrB = wrCnt[0]; fdB = fdCnt[0];
        applyStimulus(0, 12, 1'b0);
        checkOutput("t5_regq", regQ[0], expQ[0]);
        checkOutput("t5_wrcnt", 64'(wrCnt[0] - wrB), 64'd0);
        checkOutput("t5_fdone", 64'(fdCnt[0] - fdB), 64'd1);
        txBuf = '{8'h82, 8'h00, 8'h00, 8'h00};
        applyStimulus(0, 16, 1'b0);
        checkOutput("t5_rd_after", 64'(rxBuf[1]), 64'hA5);

        // Test 6: reset asserted in the middle of a read
        txBuf = '{8'h82, 8'h00, 8'h00, 8'h00};
        applyStimulus(0, 12, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("t6_misoo", 64'(misoPin), 64'h0);
        checkOutput("t6_misooe", 64'(misoOePin), 64'h0);
        checkOutput("t6_wraddr", 64'(wrAddr[1]), 64'h0);
        checkOutput("t6_wrdata", 64'(wrData[0]), 64'h0);
        checkOutput("t6_regq0", regQ[0], 64'h0);
        checkOutput("t6_regq3", regQ[3], 64'h0);
        ssnPin[0]  = 1'b1;
        sckPin[0]  = 1'b0;
        mosiPin[0] = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        for (int m = 0; m < 4; m++) expQ[m] = '0;
        txBuf = '{8'h03, 8'h5A, 8'h00, 8'h00};
        wrB = wrCnt[0]; fdB = fdCnt[0];
        applyStimulus(0, 16, 1'b0);
        setExp(0, 3, 8'h5A);
        checkOutput("t6_regq_after", regQ[0], expQ[0]);
        checkOutput("t6_wrcnt", 64'(wrCnt[0] - wrB), 64'd1);
        checkOutput("t6_fdone", 64'(fdCnt[0] - fdB), 64'd1);
        txBuf = '{8'h83, 8'h00, 8'h00, 8'h00};
        applyStimulus(0, 16, 1'b0);
        checkOutput("t6_rd_after", 64'(rxBuf[1]), 64'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
